// File: rtl/imem_pkg.sv
// ============================================================================
// imem_pkg : shared state encoding, size defaults and byte-lane constants
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package imem_pkg;

   localparam int unsigned c_DEPTH_DEF = 32;
   localparam int unsigned c_AW_DEF    = 5;
   localparam int unsigned c_BYTE_W    = 8;

   // Little-endian lanes: the first byte of a word lands in bits [7:0]
   localparam logic [4:0] c_LANE0_LSB = 5'd0;
   localparam logic [4:0] c_LANE1_LSB = 5'd8;
   localparam logic [4:0] c_LANE2_LSB = 5'd16;
   localparam logic [4:0] c_LANE3_LSB = 5'd24;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK = 3'd3,
`endif
      S_RUN   = 3'd4
   } state_e;

   function automatic logic [4:0] lane_lsb(input logic [1:0] idx);
      case (idx)
         2'd0:    lane_lsb = c_LANE0_LSB;
         2'd1:    lane_lsb = c_LANE1_LSB;
         2'd2:    lane_lsb = c_LANE2_LSB;
         default: lane_lsb = c_LANE3_LSB;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/imem_word_assembler.sv
// ============================================================================
// imem_word_assembler : byte counter, little-endian word builder, payload sum
// Rev 1.0 -- sum only present with IMEM_LOADER_CHECKSUM_EN
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module imem_word_assembler
   import imem_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr_i,
   input  logic        accept_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        last_o
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,
   output logic [7:0]  sum_o
`endif
);

   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] word_q, word_d;
   logic [4:0]  w_lsb;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  sum_q, sum_d;
`endif

   assign w_lsb = lane_lsb(cnt_q);

   always_comb begin
      cnt_d  = cnt_q;
      word_d = word_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_d  = sum_q;
`endif
      if (clr_i) begin
         cnt_d  = '0;
         word_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_d  = '0;
`endif
      end else if (accept_i) begin
         word_d[w_lsb +: c_BYTE_W] = byte_i;
         cnt_d = cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_d = sum_q + byte_i;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         word_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q  <= '0;
`endif
      end else begin
         cnt_q  <= cnt_d;
         word_q <= word_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         sum_q  <= sum_d;
`endif
      end
   end

   assign word_o = word_q;
   assign last_o = accept_i && (cnt_q == 2'd3);
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign sum_o  = sum_q;
`endif

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : boot-byte stream to instruction-memory loader, gates CPU run
// Rev 1.0 -- optional trailing checksum byte via IMEM_LOADER_CHECKSUM_EN
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module imem_loader
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH = c_DEPTH_DEF,
   parameter int unsigned AW    = c_AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW:0]   len_words,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   input  logic [31:0]   cpu_addr,
   output logic          mem_wr_en,
   output logic [31:0]   mem_addr,
   output logic [31:0]   mem_data_in,
   output logic          cpu_run,
   output logic          done,
   output logic          err
);

   state_e        state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW:0]   len_q, len_d;
   logic          done_q, done_d;
   logic          err_q, err_d;

   logic          w_clr;
   logic          w_accept;
   logic          w_last_byte;
   logic          w_last_word;
   logic          w_len_ok;
   logic [31:0]   w_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]    w_sum;
`endif

   assign w_accept    = byte_valid && (state_q == S_LOAD);
   assign w_len_ok    = (len_words <= (AW+1)'(DEPTH));
   assign w_last_word = (({1'b0, wptr_q} + (AW+1)'(1)) == len_q);

   imem_word_assembler u_asm (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (w_clr),
      .accept_i (w_accept),
      .byte_i   (byte_data),
      .word_o   (w_word),
      .last_o   (w_last_byte)
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      .sum_o    (w_sum)
`endif
   );

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      len_d   = len_q;
      done_d  = 1'b0;
      err_d   = err_q;
      w_clr   = 1'b0;
      unique case (state_q)
         // RUN re-arms exactly like IDLE; an oversize length leaves state alone
         S_IDLE, S_RUN: begin
            if (start) begin
               if (!w_len_ok) begin
                  err_d = 1'b1;
               end else begin
                  err_d  = 1'b0;
                  w_clr  = 1'b1;
                  wptr_d = '0;
                  len_d  = len_words;
                  if (len_words == '0) begin
                     state_d = S_RUN;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_LOAD;
                  end
               end
            end
         end
         S_LOAD: begin
            if (w_last_byte) state_d = S_WRITE;
         end
         S_WRITE: begin
            wptr_d = wptr_q + AW'(1);
            if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_RUN;
               done_d  = 1'b1;
`endif
            end else begin
               state_d = S_LOAD;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (byte_valid) begin
               if (byte_data == w_sum) begin
                  state_d = S_RUN;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  err_d   = 1'b1;
               end
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         wptr_q  <= '0;
         len_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         len_q   <= len_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   assign byte_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
`else
   assign byte_ready = (state_q == S_LOAD);
`endif
   assign mem_wr_en   = (state_q == S_WRITE);
   assign mem_addr    = mem_wr_en ? {{(32-AW){1'b0}}, wptr_q} : cpu_addr;
   assign mem_data_in = w_word;
   assign cpu_run     = (state_q == S_RUN);
   assign done        = done_q;
   assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : directed self-checking bench with a write-sequence model
// Rev 1.0 -- exercises checksum cases when IMEM_LOADER_CHECKSUM_EN is defined
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_imem_loader;

   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic          clk = 1'b0;
   logic          rst_n, start, byte_valid;
   logic [AW:0]   len_words;
   logic [7:0]    byte_data;
   logic [31:0]   cpu_addr;
   logic          byte_ready, mem_wr_en, cpu_run, done, err;
   logic [31:0]   mem_addr, mem_data_in;

   always #5 clk = ~clk;

   imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len_words(len_words),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .cpu_addr(cpu_addr), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_data_in(mem_data_in), .cpu_run(cpu_run), .done(done), .err(err)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int done_seen = 0;

   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
   wr_t         exp_q[$];
   logic [31:0] exp_mem [DEPTH];
   logic [31:0] dut_mem [DEPTH];
   logic [7:0]  pl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
   endtask

   // Model: each group of four payload bytes is one word, weight 256^k for byte k
   task automatic model_push(input int n);
      for (int w = 0; w < n; w++) begin
         wr_t e;
         e.addr = 32'(w);
         e.data = 32'd0;
         for (int k = 0; k < 4; k++) e.data = e.data + (32'(pl[4*w+k]) << (8*k));
         exp_q.push_back(e);
         exp_mem[w] = e.data;
      end
   endtask

   function automatic logic [7:0] psum();
      int s = 0;
      foreach (pl[i]) s += int'(pl[i]);
      return 8'(s % 256);
   endfunction

   task automatic start_load(input int n);
      start = 1'b1;
      len_words = (AW+1)'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      chk("byte_accept_bound", 32'(waited < 100), 32'd1);
      @(posedge clk);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(psum());
`else
      @(negedge clk);
`endif
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      start = 1'b0;
      byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_cpu_run", 32'(cpu_run), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_byte_ready", 32'(byte_ready), 32'd0);
      chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Continuous compare: every write must be the next one the model expects,
   // and outside writes the memory address must track the CPU address.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         #1;
         if (done === 1'b1) done_seen++;
         chk("ready_and_run_exclusive", 32'(byte_ready & cpu_run), 32'd0);
         if (mem_wr_en === 1'b1) begin
            chk("write_was_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("write_addr", mem_addr, e.addr);
               chk("write_data", mem_data_in, e.data);
            end
            dut_mem[mem_addr[AW-1:0]] = mem_data_in;
         end else begin
            chk("mem_addr_follows_cpu", mem_addr, cpu_addr);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0;
      rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = '0;
      len_words = '0; cpu_addr = '0;
      for (int i = 0; i < DEPTH; i++) begin
         exp_mem[i] = '0;
         dut_mem[i] = '0;
      end
      @(negedge clk);
      do_reset();

      // Two-word program
      pl = '{8'h13, 8'h01, 8'h10, 8'h00, 8'h93, 8'h01, 8'h10, 8'h00};
      d0 = done_seen;
      model_push(2);
      start_load(2);
      chk("load_byte_ready", 32'(byte_ready), 32'd1);
      chk("load_cpu_run", 32'(cpu_run), 32'd0);
      foreach (pl[i]) send_byte(pl[i]);
      finish_load();
      chk("t1_cpu_run", 32'(cpu_run), 32'd1);
      chk("t1_done_pulse", 32'(done), 32'd1);
      @(negedge clk);
      chk("t1_done_low", 32'(done), 32'd0);
      chk("t1_still_run", 32'(cpu_run), 32'd1);
      chk("t1_word0", dut_mem[0], 32'h00100113);
      chk("t1_word1", dut_mem[1], 32'h00100193);
      chk("t1_done_count", 32'(done_seen - d0), 32'd1);

      // Oversize length from IDLE
      do_reset();
      start_load(33);
      chk("big_err", 32'(err), 32'd1);
      chk("big_cpu_run", 32'(cpu_run), 32'd0);
      chk("big_byte_ready", 32'(byte_ready), 32'd0);
      repeat (3) @(negedge clk);
      chk("big_err_held", 32'(err), 32'd1);
      chk("big_cpu_run_held", 32'(cpu_run), 32'd0);

      // Zero length: straight to RUN, err cleared
      d0 = done_seen;
      start_load(0);
      chk("zero_cpu_run", 32'(cpu_run), 32'd1);
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_err_cleared", 32'(err), 32'd0);
      @(negedge clk);
      chk("zero_done_low", 32'(done), 32'd0);
      chk("zero_done_count", 32'(done_seen - d0), 32'd1);

      // Reset after two of four bytes
      do_reset();
      start_load(1);
      send_byte(8'h11);
      send_byte(8'h22);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_cpu_run", 32'(cpu_run), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_err", 32'(err), 32'd0);
      chk("midrst_byte_ready", 32'(byte_ready), 32'd0);
      chk("midrst_mem_wr_en", 32'(mem_wr_en), 32'd0);
      chk("midrst_word0_kept", dut_mem[0], 32'h00100113);
      rst_n = 1'b1;
      @(negedge clk);

      // Reload from RUN while the CPU is fetching
      pl = '{8'h01, 8'h02, 8'h03, 8'h04};
      model_push(1);
      start_load(1);
      foreach (pl[i]) send_byte(pl[i]);
      finish_load();
      chk("t5_cpu_run", 32'(cpu_run), 32'd1);
      chk("t5_word0", dut_mem[0], 32'h04030201);
      cpu_addr = 32'd5;
      @(negedge clk);
      chk("t5_mem_addr_cpu", mem_addr, 32'd5);
      pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      model_push(1);
      start_load(1);
      chk("t5_run_dropped", 32'(cpu_run), 32'd0);
      chk("t5_reload_ready", 32'(byte_ready), 32'd1);
      chk("t5_mem_addr_in_load", mem_addr, 32'd5);
      send_byte(pl[0]);
      start_load(33);
      chk("t5_start_ignored_err", 32'(err), 32'd0);
      chk("t5_start_ignored_ready", 32'(byte_ready), 32'd1);
      for (int i = 1; i < 4; i++) send_byte(pl[i]);
      finish_load();
      chk("t5_rerun", 32'(cpu_run), 32'd1);
      chk("t5_reload_word0", dut_mem[0], 32'hDDCCBBAA);

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Bad checksum, then good checksum (1+2+3+4 = 0x0A)
      pl = '{8'h01, 8'h02, 8'h03, 8'h04};
      model_push(1);
      start_load(1);
      foreach (pl[i]) send_byte(pl[i]);
      send_byte(8'h0B);
      chk("ck_bad_err", 32'(err), 32'd1);
      chk("ck_bad_cpu_run", 32'(cpu_run), 32'd0);
      chk("ck_bad_byte_ready", 32'(byte_ready), 32'd0);
      model_push(1);
      start_load(1);
      foreach (pl[i]) send_byte(pl[i]);
      send_byte(8'h0A);
      chk("ck_good_run", 32'(cpu_run), 32'd1);
      chk("ck_good_done", 32'(done), 32'd1);
      chk("ck_good_err", 32'(err), 32'd0);
`endif

      repeat (2) @(negedge clk);
      chk("no_pending_writes", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < DEPTH; i++) chk("mem_image", dut_mem[i], exp_mem[i]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL take parameter DEPTH, default 32, giving the instruction-memory depth in words.
REQ-002 The module SHALL take parameter AW, default 5, giving the word-index width, equal to log2(DEPTH).
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the reset, synchronous and active-low.
REQ-005 Port start, input, 1 bit, SHALL be a single-cycle load request.
REQ-006 Port len_words, input, AW+1 bits, SHALL give the word count to load, sampled when start is accepted.
REQ-007 Ports byte_valid (input, 1), byte_data (input, 8) and byte_ready (output, 1) SHALL form the boot-byte valid/ready stream.
REQ-008 Port cpu_addr, input, 32 bits, SHALL be the CPU fetch word index.
REQ-009 Ports mem_wr_en (output, 1), mem_addr (output, 32) and mem_data_in (output, 32) SHALL drive the instruction-memory port.
REQ-010 Port cpu_run, output, 1 bit, SHALL permit the CPU to fetch and execute.
REQ-011 Port done (output, 1) SHALL pulse at load completion; port err (output, 1) SHALL flag a failed load.

Function
REQ-012 The FSM SHALL have the states IDLE, LOAD, WRITE, CHECK and RUN.
REQ-013 In IDLE, start=1 with len_words<=DEPTH SHALL move to LOAD, latch len, clear the word pointer and byte count, and clear err.
REQ-014 start with len_words>DEPTH SHALL set err, stay in IDLE and perform no write.
REQ-015 start with len_words==0 SHALL go directly to RUN and pulse done for 1 cycle.
REQ-016 byte_ready SHALL be 1 only in LOAD (and CHECK when enabled); a byte is accepted when byte_valid && byte_ready.
REQ-017 Bytes SHALL assemble little-endian: byte 0 goes to bits [7:0] and byte 3 to bits [31:24].
REQ-018 Acceptance of the 4th byte SHALL move the FSM to WRITE.
REQ-019 WRITE SHALL last exactly 1 cycle, with mem_wr_en=1, mem_addr={zeros,wptr} and mem_data_in set to the assembled word.
REQ-020 After WRITE, wptr SHALL increment; if wptr+1==len the FSM SHALL go to CHECK when enabled, else to RUN with a 1-cycle done pulse; otherwise it SHALL return to LOAD.
REQ-021 Outside WRITE, mem_wr_en SHALL be 0 and mem_addr SHALL equal cpu_addr combinationally.
REQ-022 cpu_run SHALL be 1 only in RUN.
REQ-023 start asserted in RUN SHALL enter LOAD on the next cycle, dropping cpu_run, as for IDLE, including the len checks.
REQ-024 start in LOAD, WRITE or CHECK SHALL be ignored.
REQ-025 A stall on byte_valid SHALL hold all state indefinitely, with no timeout.

Reset
REQ-026 rst_n=0 SHALL force IDLE with wptr=0, byte count=0, the word register=0, cpu_run=0, mem_wr_en=0, done=0, err=0 and byte_ready=0.
REQ-027 Reset mid-load SHALL abandon the partial word without writing it; words already written remain in memory.

Configuration
REQ-028 With IMEM_LOADER_CHECKSUM_EN defined, the block SHALL keep an 8-bit modulo-256 sum of all payload bytes, cleared on start.
REQ-029 With IMEM_LOADER_CHECKSUM_EN defined, CHECK SHALL accept exactly one byte: equal to the sum goes to RUN with a done pulse; unequal sets err and goes to IDLE.
REQ-030 Without IMEM_LOADER_CHECKSUM_EN, the CHECK state and the sum logic SHALL be absent, and the last WRITE SHALL go directly to RUN.

Structure
REQ-031 The state encoding enum, the DEPTH/AW defaults and the little-endian byte-lane constants SHALL live in the shared package imem_pkg.
REQ-032 A sub-module imem_word_assembler SHALL handle byte counting, word shifting and the checksum; the FSM and muxing stay in imem_loader.

Verification
REQ-033 start, len=2, bytes 13 01 10 00 93 01 10 00 -> writes 0x00100113 at index 0 and 0x00100193 at index 1, then cpu_run=1 and a single done pulse.
REQ-034 start, len=33 -> err=1, no mem_wr_en, cpu_run stays 0.
REQ-035 start, len=0 -> RUN with a done pulse on the next cycle and no writes.
REQ-036 Assert rst_n=0 after 2 of 4 bytes -> no write, IDLE and all outputs 0 on the next cycle.
REQ-037 With IMEM_LOADER_CHECKSUM_EN, len=1, bytes 01 02 03 04 then check byte 0x0A -> RUN; the same bytes with check byte 0x0B -> err=1 and IDLE.
REQ-038 In RUN, drive cpu_addr=5, then start with len=1 -> mem_addr follows 5 until LOAD, cpu_run falls, and the reload writes index 0.
